// File: rtl/kernel_fanout_n.sv
// kernel_fanout_n: one input stream fanned out to N buffered output streams.
// MODE 0 broadcasts every word, MODE 1 distributes words round-robin.
module kernel_fanout_n #(
   parameter int WIDTH = 16,
   parameter int N     = 3,
   parameter int DEPTH = 2,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             running,
   input  logic [WIDTH-1:0] input_S1,
   input  logic             avail_S1,
   output logic             read_S1,
   output logic [N*WIDTH-1:0] output_S2,
   output logic [N-1:0]     write_S2,
   input  logic [N-1:0]     full_S2
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = (N > 1) ? $clog2(N) : 1;

   logic [WIDTH-1:0] mem    [N][DEPTH];
   logic [PW-1:0]    rd_ptr [N];
   logic [PW-1:0]    wr_ptr [N];
   logic [CW-1:0]    count  [N];
   logic [RW-1:0]    rr;

   logic [N-1:0] wr_en;
   logic [N-1:0] space;
   logic [N-1:0] push;
   logic         space_all;
   logic         busy;
   logic         rd_en;

   // Drain enables, per-channel space and the accept decision.
   always_comb begin
      wr_en     = '0;
      space     = '0;
      push      = '0;
      space_all = 1'b1;
      busy      = 1'b0;
      for (int i = 0; i < N; i++) begin
         wr_en[i]  = (count[i] != '0) & ~full_S2[i] & ~rst;
         space[i]  = (count[i] < CW'(DEPTH)) | wr_en[i];
         space_all = space_all & space[i];
         busy      = busy | (count[i] != '0);
      end
      if (MODE == 0)
         rd_en = avail_S1 & space_all & ~rst;
      else
         rd_en = avail_S1 & space[rr] & ~rst;
      for (int i = 0; i < N; i++)
         push[i] = rd_en & ((MODE == 0) | (rr == RW'(i)));
   end

   // Pointer, occupancy and round-robin bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (push[i])
               wr_ptr[i] <= (wr_ptr[i] == PW'(DEPTH - 1)) ? '0 : wr_ptr[i] + 1'b1;
            if (wr_en[i])
               rd_ptr[i] <= (rd_ptr[i] == PW'(DEPTH - 1)) ? '0 : rd_ptr[i] + 1'b1;
            if (push[i] & ~wr_en[i])
               count[i] <= count[i] + 1'b1;
            else if (~push[i] & wr_en[i])
               count[i] <= count[i] - 1'b1;
         end
         if ((MODE != 0) && rd_en)
            rr <= (rr == RW'(N - 1)) ? '0 : rr + 1'b1;
      end
   end

   // Buffer storage; contents after reset are irrelevant.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++)
         if (push[i])
            mem[i][wr_ptr[i]] <= input_S1;
   end

   // Each channel presents its oldest buffered word.
   always_comb begin
      output_S2 = '0;
      for (int i = 0; i < N; i++)
         output_S2[i*WIDTH +: WIDTH] = mem[i][rd_ptr[i]];
   end

   assign write_S2 = wr_en;
   assign read_S1  = rd_en;
   assign running  = avail_S1 | busy;

endmodule
